sreg_ctrl: RTL and testbench

SREG_CTRL -- requirements
Module: sreg_ctrl

---
 rtl/sreg_ctrl.sv | 129 ++++++++++++
 tb/tb_sreg_ctrl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sreg_ctrl.sv
// Burst controller for a fixed-depth delay shift register: loads len elements,
// drains DEPTH-1 zero-filled shifts, and tracks output handshakes to completion.
module sreg_ctrl #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             shift_en,
    output logic             zero_fill,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done
);

    // One spare bit beyond max(LEN_W, 8) holds len + DEPTH - 1 without wrap.
    localparam int unsigned CW = ((LEN_W > 8) ? LEN_W : 8) + 1;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StDrain,
        StFlush,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [LEN_W-1:0] in_cnt_q, in_cnt_d;
    logic [CW-1:0]    sh_cnt_q, sh_cnt_d;
    logic [CW-1:0]    out_cnt_q, out_cnt_d;
    logic             out_valid_q, out_valid_d;
    logic [CW-1:0]    len_ext;
    logic [CW-1:0]    last_sh;
    logic             out_hs;
    logic             load_go;

    assign len_ext  = {{(CW - LEN_W){1'b0}}, len_q};
    assign last_sh  = len_ext + CW'(DEPTH - 2);
    assign out_hs   = out_valid_q && out_ready;
    assign load_go  = in_valid && (!out_valid_q || out_ready);

    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        in_cnt_d  = in_cnt_q;
        sh_cnt_d  = sh_cnt_q;
        out_cnt_d = out_cnt_q;
        in_ready  = 1'b0;
        shift_en  = 1'b0;
        zero_fill = 1'b0;
        done      = 1'b0;

        case (state_q)
            StIdle: begin
                if (start) begin
                    len_d     = len;
                    in_cnt_d  = '0;
                    sh_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = (len == '0) ? StDone : StLoad;
                end
            end
            StLoad: begin
                in_ready = load_go;
                shift_en = load_go;
                if (load_go) begin
                    in_cnt_d = in_cnt_q + LEN_W'(1);
                    if (in_cnt_q == len_q - LEN_W'(1)) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                zero_fill = 1'b1;
                shift_en  = !out_valid_q || out_ready;
                if (shift_en && (sh_cnt_q == last_sh)) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // Only the final element can be outstanding here.
                if (out_hs && (out_cnt_q + CW'(1) == len_ext)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (shift_en) begin
            sh_cnt_d = sh_cnt_q + CW'(1);
        end
        if (out_hs) begin
            out_cnt_d = out_cnt_q + CW'(1);
        end
        out_valid_d = (shift_en && (sh_cnt_q >= CW'(DEPTH - 1))) || (out_valid_q && !out_ready);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            len_q       <= '0;
            in_cnt_q    <= '0;
            sh_cnt_q    <= '0;
            out_cnt_q   <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            in_cnt_q    <= in_cnt_d;
            sh_cnt_q    <= sh_cnt_d;
            out_cnt_q   <= out_cnt_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_sreg_ctrl.sv
// Bench for sreg_ctrl: drives a behavioural delay line and checks burst ordering,
// shift totals, stall behaviour, reset abort and exact cycle timing.
module tb_sreg_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned LEN_W = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [LEN_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic             shift_en;
    logic             zero_fill;
    logic             out_valid;
    logic             out_ready;
    logic             busy;
    logic             done;

    logic [15:0] din;
    logic [15:0] sr [DEPTH];
    logic [15:0] exp_q [$];

    int errors = 0;
    int checks = 0;

    sreg_ctrl #(.DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .len       (len),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .shift_en  (shift_en),
        .zero_fill (zero_fill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // The controlled delay line; it has no reset, so stale data survives rst.
    always_ff @(posedge clk) begin
        if (shift_en) begin
            sr[0] <= zero_fill ? 16'd0 : din;
            for (int i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
        end
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        int len;
        int iv_mode;   // 0 always valid, 1 toggle, 2 random
        int or_mode;   // 0 always ready, 1 random, 2 five-cycle stall at first out_valid
        bit mid_start;
        int exp_shifts;
        int exp_outs;
    } vec_t;

    // Entered just after a rising edge; leaves just after a rising edge.
    task automatic run_burst(input int blen, input int iv_mode, input int or_mode,
                             input bit mid_start, output int n_shift, output int n_out,
                             output int n_in, output int n_done, output int n_ovcyc,
                             output int done_cyc);
        int  stall_left;
        bit  stalled_once;
        bit  in_stall;
        bit  finished;
        logic [15:0] hold;
        n_shift = 0; n_out = 0; n_in = 0; n_done = 0; n_ovcyc = 0; done_cyc = 0;
        stall_left = 0; stalled_once = 0; finished = 0; hold = '0;
        exp_q.delete();
        din = 16'($urandom);
        start = 1'b1; len = 16'(blen); in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; len = 16'($urandom);
        chk("start_accepted", busy, 1);
        for (int cyc = 1; cyc < 2000; cyc++) begin
            in_valid = (iv_mode == 0) ? 1'b1 :
                       (iv_mode == 1) ? 1'(cyc % 2) : 1'($urandom_range(0, 1));
            in_stall = 0;
            if (or_mode == 2) begin
                if (stall_left > 0) begin
                    out_ready = 1'b0; stall_left--; in_stall = 1;
                end else if (out_valid && !stalled_once) begin
                    stalled_once = 1; out_ready = 1'b0; stall_left = 4; in_stall = 1;
                    hold = sr[DEPTH-1];
                end else begin
                    out_ready = 1'b1;
                end
            end else begin
                out_ready = (or_mode == 0) ? 1'b1 : 1'($urandom_range(0, 3) != 0);
            end
            if (mid_start && cyc == 2) begin
                start = 1'b1; len = 16'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (shift_en) n_shift++;
            if (out_valid) n_ovcyc++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) chk("out_extra", 1, 0);
                else chk("out_data", sr[DEPTH-1], exp_q.pop_front());
                n_out++;
            end
            if (in_ready) begin
                exp_q.push_back(din);
                n_in++;
            end
            chk("hold_no_shift", shift_en && out_valid && !out_ready, 0);
            chk("in_ready_needs_valid", in_ready && !in_valid, 0);
            chk("zero_fill_no_in_ready", zero_fill && in_ready, 0);
            if (in_stall) begin
                chk("stall_shift_en", shift_en, 0);
                chk("stall_in_ready", in_ready, 0);
                chk("stall_data_hold", sr[DEPTH-1], hold);
            end
            if (done) begin
                n_done++; done_cyc = cyc; finished = 1;
            end
            @(posedge clk); #1;
            if (in_ready) din = 16'($urandom);
            if (finished) break;
        end
        start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        if (!finished) chk("burst_timeout", 0, 1);
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    initial begin
        vec_t vecs [9];
        int ns, no, ni, nd, nov, dc;
        logic [15:0] ir_m, zf_m, ov_m, dn_m, bz_m;
        int sh;
        int zf_seen;

        vecs[0] = '{3,  0, 0, 0, 10, 3};
        vecs[1] = '{0,  0, 0, 0, 0,  0};
        vecs[2] = '{20, 0, 2, 0, 27, 20};
        vecs[3] = '{12, 1, 0, 0, 19, 12};
        vecs[4] = '{12, 0, 0, 1, 19, 12};
        vecs[5] = '{1,  0, 0, 0, 8,  1};
        vecs[6] = '{7,  2, 1, 0, 14, 7};
        vecs[7] = '{8,  0, 1, 0, 15, 8};
        vecs[8] = '{9,  1, 1, 0, 16, 9};

        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; out_ready = 1'b1; din = '0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Exact cycle timing of a len=3 burst.
        ir_m = '0; zf_m = '0; ov_m = '0; dn_m = '0; bz_m = '0; sh = 0;
        start = 1'b1; len = 16'd3; in_valid = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            ir_m[c] = in_ready; zf_m[c] = zero_fill; ov_m[c] = out_valid;
            dn_m[c] = done; bz_m[c] = busy;
            if (shift_en) sh++;
            @(posedge clk); #1;
            start = 1'b0;
        end
        in_valid = 1'b0;
        chk("t3_in_ready_cycles", ir_m, 16'h000E);
        chk("t3_zero_fill_cycles", zf_m, 16'h07F0);
        chk("t3_out_valid_cycles", ov_m, 16'h0E00);
        chk("t3_done_cycle", dn_m, 16'h1000);
        chk("t3_busy_cycles", bz_m, 16'h1FFE);
        chk("t3_shift_total", sh, 10);

        for (int v = 0; v < 9; v++) begin
            run_burst(vecs[v].len, vecs[v].iv_mode, vecs[v].or_mode, vecs[v].mid_start,
                      ns, no, ni, nd, nov, dc);
            chk($sformatf("vec%0d_shifts", v), ns, vecs[v].exp_shifts);
            chk($sformatf("vec%0d_outs", v), no, vecs[v].exp_outs);
            chk($sformatf("vec%0d_consumed", v), ni, vecs[v].len);
            chk($sformatf("vec%0d_done_pulses", v), nd, 1);
            chk($sformatf("vec%0d_leftover", v), exp_q.size(), 0);
            if (vecs[v].len == 0) begin
                chk("len0_no_out_valid", nov, 0);
                chk("len0_done_cycle", dc, 1);
            end
        end

        // Reset in DRAIN aborts the burst; next burst must not leak stale data.
        start = 1'b1; len = 16'd10; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        zf_seen = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            chk("abort_no_done", done, 0);
            if (zero_fill) zf_seen++;
            if (zf_seen == 2) break;
            @(posedge clk); #1;
        end
        chk("abort_reached_drain", zf_seen, 2);
        #2 rst = 1'b1;
        #1;
        chk("abort_in_ready", in_ready, 0);
        chk("abort_shift_en", shift_en, 0);
        chk("abort_zero_fill", zero_fill, 0);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("abort_held_done", done, 0);
        rst = 1'b0;
        run_burst(2, 0, 0, 0, ns, no, ni, nd, nov, dc);
        chk("post_rst_outs", no, 2);
        chk("post_rst_ov_cycles", nov, 2);
        chk("post_rst_shifts", ns, 9);
        chk("post_rst_done", nd, 1);

        // Randomized bursts against the ordering/count model.
        for (int k = 0; k < 12; k++) begin
            int rl;
            rl = $urandom_range(1, 40);
            run_burst(rl, $urandom_range(0, 2), $urandom_range(0, 1), 0,
                      ns, no, ni, nd, nov, dc);
            chk($sformatf("rnd%0d_shifts", k), ns, rl + DEPTH - 1);
            chk($sformatf("rnd%0d_outs", k), no, rl);
            chk($sformatf("rnd%0d_consumed", k), ni, rl);
            chk($sformatf("rnd%0d_done", k), nd, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
